// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory front end.
// Holds the default widths and the FSM state encodings.
package cpu_mem_pkg;

  localparam int ADDR_W_DEF  = 9;
  localparam int DATA_W_DEF  = 32;
  localparam int RD_WAIT_DEF = 1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD_WAIT  = 3'd1;
  localparam logic [2:0] ST_RD_CAP   = 3'd2;
  localparam logic [2:0] ST_WR_SETUP = 3'd3;
  localparam logic [2:0] ST_WR_PULSE = 3'd4;
  localparam logic [2:0] ST_WR_HOLD  = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    RD_WAIT_S = ST_RD_WAIT,
    RD_CAP    = ST_RD_CAP,
    WR_SETUP  = ST_WR_SETUP,
    WR_PULSE  = ST_WR_PULSE,
    WR_HOLD   = ST_WR_HOLD,
    DONE      = ST_DONE
  } mem_state_t;

endpackage

// File: rtl/mem_access_ctrl_mdr_reg.sv
// Memory data register: loads either from the datapath bus or from RAM read data.
// RAM data takes priority because it is only selected during read capture.
module mdr_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              load_bus,
  input  logic              load_mem,
  input  logic [DATA_W-1:0] bus_data,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clock) begin
    if (clear) begin
      q <= '0;
    end else if (load_mem) begin
      q <= mem_data;
    end else if (load_bus) begin
      q <= bus_data;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-side front end: owns MAR/MDR and sequences reads and framed writes to the RAM.
// Every RAM-facing output comes from registers, so no input can glitch the strobes.
module mem_access_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RD_WAIT = RD_WAIT_DEF
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic [DATA_W-1:0] Mdatain,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-1:0] MDR_q,
  output logic [ADDR_W-1:0] MAR_q,
  output logic              mem_busy,
  output logic              mem_done
);

  mem_state_t        state;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] mar;
  logic              unused_bus_bits;

  // Only the low address bits of the bus feed MAR; the rest are deliberately dropped.
  assign unused_bus_bits = ^BusMuxOut[DATA_W-1:ADDR_W];

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
      cnt   <= '0;
      mar   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MARin) begin
            mar <= BusMuxOut[ADDR_W-1:0];
          end
          if (mem_rd) begin
            state <= RD_WAIT_S;
            cnt   <= 3'(RD_WAIT - 1);
          end else if (mem_wr) begin
            state <= WR_SETUP;
          end
        end
        RD_WAIT_S: begin
          if (cnt == 3'd0) begin
            state <= RD_CAP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RD_CAP:   state <= DONE;
        WR_SETUP: state <= WR_PULSE;
        WR_PULSE: state <= WR_HOLD;
        WR_HOLD:  state <= DONE;
        DONE:     state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  mdr_reg #(
    .DATA_W(DATA_W)
  ) u_mdr (
    .clock    (clock),
    .clear    (clear),
    .load_bus (MDRin && (state == IDLE)),
    .load_mem (state == RD_CAP),
    .bus_data (BusMuxOut),
    .mem_data (Mdatain),
    .q        (MDR_q)
  );

  // Strobes and status are pure decodes of the state register.
  assign ram_read  = (state == RD_WAIT_S) || (state == RD_CAP);
  assign ram_write = (state == WR_PULSE);
  assign mem_busy  = (state != IDLE) && (state != DONE);
  assign mem_done  = (state == DONE);
  assign ram_addr  = mar;
  assign ram_wdata = MDR_q;
  assign MAR_q     = mar;

  strobe_exclusive: assert property (@(posedge clock) disable iff (clear)
    !(ram_read && ram_write));

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, hand-written clear-mid-write sequence,
// then randomized transactions scored against a transaction-level memory model.
module tb_mem_access_ctrl;

  logic        clock = 1'b0;
  logic        clear;
  logic        MARin, MDRin, mem_rd, mem_wr;
  logic [31:0] BusMuxOut;
  wire  [31:0] Mdatain;
  logic        ram_read, ram_write, mem_busy, mem_done;
  logic [8:0]  ram_addr, MAR_q;
  logic [31:0] ram_wdata, MDR_q;

  logic [31:0] ram [512];
  logic        ramFill, ramPokeEn;
  logic [8:0]  ramPokeAddr;
  logic [31:0] ramPokeData;

  int passed = 0;
  int total  = 0;

  int obsLat, obsRead, obsWrite, obsWriteAt, obsBusy;

  logic [31:0] refMem [512];
  logic [8:0]  refMar;
  logic [31:0] refMdr;

  typedef struct {
    logic        marin;
    logic        mdrin;
    logic        rd;
    logic        wr;
    logic        busyLoad;
    logic [31:0] bus;
    logic [8:0]  expMar;
    logic [31:0] expMdr;
    int          expLat;
  } txn_t;

  txn_t dirTab [10];

  always #5 clock = ~clock;

  mem_access_ctrl dut (
    .clock     (clock),
    .clear     (clear),
    .MARin     (MARin),
    .MDRin     (MDRin),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .BusMuxOut (BusMuxOut),
    .Mdatain   (Mdatain),
    .ram_read  (ram_read),
    .ram_write (ram_write),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .MDR_q     (MDR_q),
    .MAR_q     (MAR_q),
    .mem_busy  (mem_busy),
    .mem_done  (mem_done)
  );

  // Synchronous 512x32 RAM with bench-side fill and poke ports.
  always @(posedge clock) begin
    if (ramFill) begin
      for (int i = 0; i < 512; i++) ram[i] <= 32'(i) * 32'h9E37_79B1;
    end else if (ramPokeEn) begin
      ram[ramPokeAddr] <= ramPokeData;
    end else if (ram_write) begin
      ram[ram_addr] <= ram_wdata;
    end
  end

  assign Mdatain = ram_read ? ram[ram_addr] : 32'hzzzz_zzzz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic poke(input logic [8:0] addr, input logic [31:0] data);
    @(negedge clock);
    ramPokeEn = 1'b1; ramPokeAddr = addr; ramPokeData = data;
    @(negedge clock);
    ramPokeEn = 1'b0;
  endtask

  // Drives one request in IDLE and observes strobes until mem_done or a cycle budget expires.
  task automatic applyStimulus(input txn_t t);
    @(negedge clock);
    MARin = t.marin; MDRin = t.mdrin; mem_rd = t.rd; mem_wr = t.wr; BusMuxOut = t.bus;
    @(negedge clock);
    mem_rd = 1'b0; mem_wr = 1'b0;
    if (t.busyLoad) begin
      MARin = 1'b1; MDRin = 1'b1; BusMuxOut = 32'hFFFF_FFFF;
    end else begin
      MARin = 1'b0; MDRin = 1'b0;
    end
    obsLat = -1; obsRead = 0; obsWrite = 0; obsWriteAt = 0; obsBusy = 0;
    if (t.rd || t.wr) begin
      for (int c = 1; c <= 20; c++) begin
        if (c > 1) @(negedge clock);
        if (ram_read) obsRead++;
        if (ram_write) begin
          obsWrite++;
          if (obsWriteAt == 0) obsWriteAt = c;
        end
        if (mem_busy) obsBusy++;
        if (mem_done) begin
          obsLat = c;
          break;
        end
      end
    end else begin
      if (mem_busy) obsBusy++;
    end
    MARin = 1'b0; MDRin = 1'b0;
  endtask

  task automatic checkOutput(input txn_t t);
    if (t.rd || t.wr) begin
      check("latency", obsLat, t.expLat);
      check("read_cycles", obsRead, t.rd ? 2 : 0);
      check("write_cycles", obsWrite, (!t.rd && t.wr) ? 1 : 0);
      if (!t.rd && t.wr) check("write_pulse_cycle", obsWriteAt, 2);
      check("busy_cycles", obsBusy, t.expLat - 1);
    end else begin
      check("busy_when_idle", obsBusy, 0);
    end
    check("MAR_q", {23'd0, MAR_q}, {23'd0, t.expMar});
    check("MDR_q", MDR_q, t.expMdr);
  endtask

  initial begin
    txn_t t;
    int   cnt, mism;

    clear = 1'b1; MARin = 1'b0; MDRin = 1'b0; mem_rd = 1'b1; mem_wr = 1'b0;
    BusMuxOut = 32'hFFFF_FFFF; ramFill = 1'b0; ramPokeEn = 1'b0;
    ramPokeAddr = '0; ramPokeData = '0;
    repeat (2) @(negedge clock);
    mem_rd = 1'b0;
    check("reset_ram_read", {31'd0, ram_read}, 32'd0);
    check("reset_ram_write", {31'd0, ram_write}, 32'd0);
    check("reset_busy", {31'd0, mem_busy}, 32'd0);
    check("reset_done", {31'd0, mem_done}, 32'd0);
    check("reset_MAR", {23'd0, MAR_q}, 32'd0);
    check("reset_MDR", MDR_q, 32'd0);

    poke(9'h055, 32'hDEAD_BEEF);
    poke(9'h010, 32'h0BAD_F00D);
    poke(9'h000, 32'hA5A5_0000);
    poke(9'h1F0, 32'h0000_0000);
    poke(9'h005, 32'h0000_0000);
    clear = 1'b0;

    // marin, mdrin, rd, wr, busyLoad, bus, expMar, expMdr, expLat
    dirTab[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0055, 9'h055, 32'hDEAD_BEEF, 3};
    dirTab[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_01F0, 9'h1F0, 32'hDEAD_BEEF, 0};
    dirTab[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 9'h1F0, 32'h1234_5678, 4};
    dirTab[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 9'h1F0, 32'h0000_0000, 0};
    dirTab[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 9'h1F0, 32'h1234_5678, 3};
    dirTab[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 9'h010, 32'h0BAD_F00D, 3};
    dirTab[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 9'h010, 32'h0BAD_F00D, 3};
    dirTab[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 9'h000, 32'hA5A5_0000, 3};
    dirTab[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FE05, 9'h005, 32'hA5A5_0000, 0};
    dirTab[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 9'h005, 32'hA5A5_0000, 4};

    for (int i = 0; i < 10; i++) begin
      applyStimulus(dirTab[i]);
      checkOutput(dirTab[i]);
    end
    check("mem_1F0_written", ram[9'h1F0], 32'h1234_5678);
    check("mem_010_untouched", ram[9'h010], 32'h0BAD_F00D);
    check("mem_055_untouched", ram[9'h055], 32'hDEAD_BEEF);
    check("mem_005_written", ram[9'h005], 32'hA5A5_0000);

    // Clear arrives while the write strobe is high; the access must be abandoned.
    @(negedge clock);
    MDRin = 1'b1; mem_wr = 1'b1; BusMuxOut = 32'h7777_7777;
    @(negedge clock);
    MDRin = 1'b0; mem_wr = 1'b0;
    @(negedge clock);
    check("pulse_before_clear", {31'd0, ram_write}, 32'd1);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("clear_ram_write", {31'd0, ram_write}, 32'd0);
    check("clear_busy", {31'd0, mem_busy}, 32'd0);
    check("clear_MAR", {23'd0, MAR_q}, 32'd0);
    check("clear_MDR", MDR_q, 32'd0);
    cnt = 0;
    repeat (10) begin
      @(negedge clock);
      if (ram_write || mem_done || mem_busy) cnt++;
    end
    check("no_activity_after_clear", cnt, 0);
    check("mem_000_not_rewritten", ram[9'h000], 32'hA5A5_0000);

    // Randomized phase against a transaction-level model of MAR, MDR and memory.
    @(negedge clock);
    clear = 1'b1; ramFill = 1'b1;
    @(negedge clock);
    clear = 1'b0; ramFill = 1'b0;
    for (int i = 0; i < 512; i++) refMem[i] = 32'(i) * 32'h9E37_79B1;
    refMar = '0;
    refMdr = '0;

    for (int n = 0; n < 60; n++) begin
      int op;
      t.bus = $urandom;
      t.bus[8:0] = 9'($urandom_range(0, 7)) + ((($urandom % 2) == 1) ? 9'h1F8 : 9'h000);
      t.marin = 1'($urandom % 2);
      t.mdrin = 1'($urandom % 2);
      op = int'($urandom % 4);
      t.rd = op[0];
      t.wr = op[1];
      t.busyLoad = 1'($urandom % 2);
      if (t.marin) refMar = t.bus[8:0];
      if (t.mdrin) refMdr = t.bus;
      if (t.rd) refMdr = refMem[refMar];
      else if (t.wr) refMem[refMar] = refMdr;
      t.expMar = refMar;
      t.expMdr = refMdr;
      t.expLat = t.rd ? 3 : (t.wr ? 4 : 0);
      applyStimulus(t);
      checkOutput(t);
    end
    @(negedge clock);
    mism = 0;
    for (int i = 0; i < 512; i++) if (ram[i] !== refMem[i]) mism++;
    check("mem_image", mism, 0);

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
